// File: rtl/obi_mem_arbiter.sv
// Two-master OBI arbiter (instruction fetch + data LSU) sharing one memory port.
// In-order responses are steered back to their issuer through a small ID FIFO.
module obi_mem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_OUTST = 2,
    parameter int RR_EN     = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                instr_req_i,
    output logic                instr_gnt_o,
    input  logic [ADDR_W-1:0]   instr_addr_i,
    output logic                instr_rvalid_o,
    output logic [DATA_W-1:0]   instr_rdata_o,
    output logic                instr_err_o,
    input  logic                data_req_i,
    output logic                data_gnt_o,
    input  logic [ADDR_W-1:0]   data_addr_i,
    input  logic                data_we_i,
    input  logic [DATA_W/8-1:0] data_be_i,
    input  logic [DATA_W-1:0]   data_wdata_i,
    output logic                data_rvalid_o,
    output logic [DATA_W-1:0]   data_rdata_o,
    output logic                data_err_o,
    output logic                mem_req_o,
    input  logic                mem_gnt_i,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic                mem_rvalid_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    input  logic                mem_err_i,
    output logic                unexp_rsp_o
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = $clog2(MAX_OUTST + 1);

    logic [CNT_W-1:0]     cnt, cnt_nxt, wr_idx;
    logic [MAX_OUTST-1:0] ids, ids_nxt;   // ids[0] is the FIFO head; 1 = data
    logic full, empty, sel_data, locked, lock_data, rr_data;
    logic hs, push, pop;

    assign full  = (cnt == CNT_W'(MAX_OUTST));
    assign empty = (cnt == '0);

    // A stalled request keeps its master until granted so the address phase stays stable.
    always_comb begin
        sel_data = data_req_i;
        if (locked)
            sel_data = lock_data;
        else if (RR_EN != 0)
            sel_data = data_req_i & (~instr_req_i | rr_data);
    end

    assign mem_req_o   = (instr_req_i | data_req_i) & ~full;
    assign mem_addr_o  = sel_data ? data_addr_i  : instr_addr_i;
    assign mem_we_o    = sel_data & data_we_i;
    assign mem_be_o    = sel_data ? data_be_i    : {BE_W{1'b1}};
    assign mem_wdata_o = sel_data ? data_wdata_i : '0;

    assign hs          = mem_req_o & mem_gnt_i;
    assign data_gnt_o  = hs & sel_data;
    assign instr_gnt_o = hs & ~sel_data;

    assign push = hs;
    assign pop  = mem_rvalid_i & ~empty;

    assign instr_rvalid_o = pop & ~ids[0];
    assign data_rvalid_o  = pop & ids[0];
    assign instr_rdata_o  = mem_rdata_i;
    assign data_rdata_o   = mem_rdata_i;
    assign instr_err_o    = mem_err_i;
    assign data_err_o     = mem_err_i;

    // Shift-down FIFO: pop shifts toward the head, push lands behind the last valid entry.
    always_comb begin
        ids_nxt = pop ? (ids >> 1) : ids;
        wr_idx  = cnt - CNT_W'(pop);
        for (int i = 0; i < MAX_OUTST; i++)
            if (push && wr_idx == CNT_W'(i))
                ids_nxt[i] = sel_data;
        cnt_nxt = cnt + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt         <= '0;
            ids         <= '0;
            locked      <= 1'b0;
            lock_data   <= 1'b0;
            rr_data     <= 1'b1;
            unexp_rsp_o <= 1'b0;
        end else begin
            cnt       <= cnt_nxt;
            ids       <= ids_nxt;
            locked    <= mem_req_o & ~mem_gnt_i;
            lock_data <= sel_data;
            if (hs)
                rr_data <= ~sel_data;
            if (mem_rvalid_i && empty)
                unexp_rsp_o <= 1'b1;
        end
    end
endmodule

// File: tb/tb_obi_mem_arbiter.sv
// Bench for obi_mem_arbiter: directed scenarios plus random OBI-compliant traffic
// checked against a queue-based reference model.
module tb_obi_mem_arbiter;
    localparam int AW = 32, DW = 32, MO = 2;

    logic clk = 1'b0, rst = 1'b1;
    logic          instr_req, instr_gnt, instr_rvalid, instr_err;
    logic [AW-1:0] instr_addr;
    logic [DW-1:0] instr_rdata;
    logic          data_req, data_gnt, data_we, data_rvalid, data_err;
    logic [AW-1:0] data_addr;
    logic [3:0]    data_be;
    logic [DW-1:0] data_wdata, data_rdata;
    logic          mem_req, mem_gnt, mem_we, mem_rvalid, mem_err, unexp_rsp;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_be;
    logic [DW-1:0] mem_wdata, mem_rdata;

    obi_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(MO), .RR_EN(1)) dut (
        .clk_i(clk), .rst_i(rst),
        .instr_req_i(instr_req), .instr_gnt_o(instr_gnt), .instr_addr_i(instr_addr),
        .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata), .instr_err_o(instr_err),
        .data_req_i(data_req), .data_gnt_o(data_gnt), .data_addr_i(data_addr),
        .data_we_i(data_we), .data_be_i(data_be), .data_wdata_i(data_wdata),
        .data_rvalid_o(data_rvalid), .data_rdata_o(data_rdata), .data_err_o(data_err),
        .mem_req_o(mem_req), .mem_gnt_i(mem_gnt), .mem_addr_o(mem_addr), .mem_we_o(mem_we),
        .mem_be_o(mem_be), .mem_wdata_o(mem_wdata), .mem_rvalid_i(mem_rvalid),
        .mem_rdata_i(mem_rdata), .mem_err_i(mem_err), .unexp_rsp_o(unexp_rsp)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: queue of outstanding owners (0=instr, 1=data), favoured master,
    // master held by a stalled request (-1 when none), sticky unexpected-response flag.
    int q[$];
    int fav_d = 1;
    int held  = -1;
    bit m_unexp = 1'b0;
    bit e_igt = 1'b0, e_dgt = 1'b0;

    task automatic idle();
        instr_req = 0; instr_addr = '0;
        data_req = 0; data_addr = '0; data_we = 0; data_be = '0; data_wdata = '0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = '0; mem_err = 0;
    endtask

    // Inputs are set at the negedge; compare a little later, advance the model at posedge.
    task automatic cyc();
        bit ereq, hs, full;
        int w;
        #1;
        if (rst) begin
            q.delete(); fav_d = 1; held = -1; m_unexp = 0;
        end
        full = (q.size() == MO);
        ereq = (instr_req || data_req) && !full;
        if (held >= 0) w = held;
        else if (instr_req && data_req) w = fav_d;
        else w = data_req ? 1 : 0;
        hs = ereq && mem_gnt;
        check("mem_req", mem_req, ereq);
        check("instr_gnt", instr_gnt, hs && w == 0);
        check("data_gnt", data_gnt, hs && w == 1);
        if (ereq) begin
            check("mem_addr", mem_addr, (w == 1) ? data_addr : instr_addr);
            check("mem_we", mem_we, (w == 1) ? data_we : 1'b0);
            check("mem_be", mem_be, (w == 1) ? data_be : 4'hf);
            if (w == 1) check("mem_wdata", mem_wdata, data_wdata);
        end
        check("instr_rvalid", instr_rvalid, mem_rvalid && q.size() > 0 && q[0] == 0);
        check("data_rvalid", data_rvalid, mem_rvalid && q.size() > 0 && q[0] == 1);
        check("instr_rdata", instr_rdata, mem_rdata);
        check("data_rdata", data_rdata, mem_rdata);
        check("instr_err", instr_err, mem_err);
        check("data_err", data_err, mem_err);
        check("unexp_rsp", unexp_rsp, m_unexp);
        e_igt = hs && w == 0;
        e_dgt = hs && w == 1;
        @(posedge clk);
        if (!rst) begin
            if (mem_rvalid) begin
                if (q.size() > 0) void'(q.pop_front());
                else m_unexp = 1;
            end
            if (hs) begin
                q.push_back(w);
                fav_d = (w == 0) ? 1 : 0;
            end
            held = (ereq && !mem_gnt) ? w : -1;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        idle();
        rst = 1;
        cyc();
        cyc();
        rst = 0;
    endtask

    // Masters obey OBI: a pending request and its attributes stay put until granted.
    task automatic rnd_cycle();
        if (!instr_req || e_igt) begin
            instr_req  = 1'($urandom % 2);
            instr_addr = $urandom;
        end
        if (!data_req || e_dgt) begin
            data_req   = 1'($urandom % 2);
            data_addr  = $urandom;
            data_we    = 1'($urandom % 2);
            data_be    = 4'($urandom);
            data_wdata = $urandom;
        end
        mem_gnt    = ($urandom % 4) != 0;
        mem_rvalid = (q.size() > 0) && ($urandom % 2 == 1);
        mem_rdata  = $urandom;
        mem_err    = 1'($urandom % 2);
        cyc();
    endtask

    initial begin
        idle();
        @(negedge clk);
        do_reset();

        // single instruction fetch and its response
        instr_req = 1; instr_addr = 32'h80; mem_gnt = 1;
        #1 check("t1_igt", instr_gnt, 1);
        cyc();
        instr_req = 0; mem_gnt = 0; mem_rvalid = 1; mem_rdata = 32'h13;
        #1 check("t1_irv", instr_rvalid, 1);
        check("t1_rdata", instr_rdata, 32'h13);
        check("t1_drv", data_rvalid, 0);
        cyc();
        idle();

        // round-robin: both continuously requesting alternate D,I,D,I
        do_reset();
        for (int k = 0; k < 5; k++) begin
            instr_req = (k < 4); data_req = (k < 4);
            instr_addr = 32'h1000 + k; data_addr = 32'h2000 + k; data_be = 4'hf;
            mem_gnt = 1; mem_rvalid = (k > 0); mem_rdata = 32'(k);
            #1;
            if (k < 4) begin
                check("t2_dgnt", data_gnt, (k % 2) == 0);
                check("t2_ignt", instr_gnt, (k % 2) == 1);
            end
            if (k > 0) begin
                check("t2_drv", data_rvalid, ((k - 1) % 2) == 0);
                check("t2_irv", instr_rvalid, ((k - 1) % 2) == 1);
            end
            cyc();
        end
        idle();

        // stalled data write holds the address phase while instr joins
        do_reset();
        data_req = 1; data_we = 1; data_addr = 32'h100; data_be = 4'hf; data_wdata = 32'hcafe;
        instr_addr = 32'h40;
        for (int k = 0; k < 3; k++) begin
            instr_req = (k >= 1);
            #1 check("t3_addr", mem_addr, 32'h100);
            check("t3_we", mem_we, 1);
            cyc();
        end
        mem_gnt = 1;
        #1 check("t3_dgnt", data_gnt, 1);
        cyc();
        data_req = 0;
        #1 check("t3_ignt", instr_gnt, 1);
        check("t3_iaddr", mem_addr, 32'h40);
        cyc();
        idle();
        mem_rvalid = 1;
        cyc();
        cyc();
        idle();

        // outstanding limit; a same-cycle pop does not release the block
        do_reset();
        instr_req = 1; instr_addr = 32'h300; mem_gnt = 1;
        cyc();
        cyc();
        #1 check("t4_full_req", mem_req, 0);
        cyc();
        mem_rvalid = 1;
        #1 check("t4_pop_req", mem_req, 0);
        cyc();
        mem_rvalid = 0;
        #1 check("t4_req_again", mem_req, 1);
        check("t4_igt", instr_gnt, 1);
        cyc();
        instr_req = 0; mem_rvalid = 1;
        cyc();
        cyc();
        idle();

        // response with nothing outstanding
        do_reset();
        mem_rvalid = 1;
        #1 check("t5_irv", instr_rvalid, 0);
        check("t5_drv", data_rvalid, 0);
        cyc();
        mem_rvalid = 0;
        repeat (3) begin
            #1 check("t5_unexp", unexp_rsp, 1);
            cyc();
        end

        // reset with one transaction in flight
        do_reset();
        check("t6_unexp_clr", unexp_rsp, 0);
        data_req = 1; data_addr = 32'h500; data_be = 4'hf; mem_gnt = 1;
        cyc();
        idle();
        rst = 1;
        #1 check("t6_rst_req", mem_req, 0);
        check("t6_rst_unexp", unexp_rsp, 0);
        cyc();
        rst = 0;
        mem_rvalid = 1;
        #1 check("t6_late_drv", data_rvalid, 0);
        cyc();
        mem_rvalid = 0;
        #1 check("t6_unexp", unexp_rsp, 1);
        cyc();

        // random traffic
        do_reset();
        repeat (600) rnd_cycle();
        idle();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
